// File: rtl/servo_pwm_bank.sv
`default_nettype none
// ============================================================================
// Module      : servo_pwm_bank
// Description : Multi-channel servo PWM generator with saturating targets,
//               per-frame slew limiting and frame-aligned pulse updates.
// Revision    : 1.0 - initial release
// ============================================================================
module servo_pwm_bank #(
    parameter int CHANNELS     = 4,
    parameter int WIDTH        = 12,
    parameter int TICK_DIV     = 1000,
    parameter int PERIOD_TICKS = 2000,
    parameter int MIN_TICKS    = 100,
    parameter int MAX_TICKS    = 200,
    parameter int STEP         = 1,
    parameter int SLEW         = 1,
    localparam int SEL_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [SEL_W-1:0]    sel,
    input  logic                inc,
    input  logic                dec,
    input  logic                wr_en,
    input  logic [SEL_W-1:0]    wr_ch,
    input  logic [WIDTH-1:0]    wr_data,
    output logic [CHANNELS-1:0] pwm,
    output logic                frame_start,
    output logic [CHANNELS-1:0] settled,
    output logic [WIDTH-1:0]    pos_out
);

    localparam int TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [WIDTH-1:0] c_min    = WIDTH'(MIN_TICKS);
    localparam logic [WIDTH-1:0] c_max    = WIDTH'(MAX_TICKS);
    localparam logic [WIDTH-1:0] c_center = WIDTH'((MIN_TICKS + MAX_TICKS) / 2);
    localparam logic [TCW-1:0]   c_tick_last  = TCW'(TICK_DIV - 1);
    localparam logic [WIDTH-1:0] c_frame_last = WIDTH'(PERIOD_TICKS - 1);

    logic [TCW-1:0]      r_tick_cnt;
    logic [WIDTH-1:0]    r_frame_cnt;
    logic                r_frame_start;
    logic [CHANNELS-1:0] r_pwm;
    logic [CHANNELS-1:0] r_settled;
    logic [WIDTH-1:0]    r_pos;
    logic [WIDTH-1:0]    r_tgt [CHANNELS];
    logic [WIDTH-1:0]    r_cur [CHANNELS];

    logic                w_tick;
    logic                w_wrap;
    logic [WIDTH-1:0]    w_wr_clamped;
    logic [WIDTH-1:0]    w_tgt_next [CHANNELS];
    logic [WIDTH-1:0]    w_cur_next [CHANNELS];
    logic [WIDTH-1:0]    w_pos_next;

    assign w_tick = (r_tick_cnt == c_tick_last);
    assign w_wrap = w_tick && (r_frame_cnt == c_frame_last);

    always_comb begin
        w_wr_clamped = wr_data;
        if (wr_data < c_min) begin
            w_wr_clamped = c_min;
        end else if (wr_data > c_max) begin
            w_wr_clamped = c_max;
        end
    end

    // Saturation is decided in 32-bit int arithmetic so sums never wrap.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            w_tgt_next[i] = r_tgt[i];
            if (wr_en && (int'(wr_ch) == i)) begin
                w_tgt_next[i] = w_wr_clamped;
            end else if ((int'(sel) == i) && inc && !dec) begin
                if (int'(r_tgt[i]) + STEP > MAX_TICKS) begin
                    w_tgt_next[i] = c_max;
                end else begin
                    w_tgt_next[i] = r_tgt[i] + WIDTH'(STEP);
                end
            end else if ((int'(sel) == i) && dec && !inc) begin
                if (int'(r_tgt[i]) - STEP < MIN_TICKS) begin
                    w_tgt_next[i] = c_min;
                end else begin
                    w_tgt_next[i] = r_tgt[i] - WIDTH'(STEP);
                end
            end
        end
    end

    // Slew uses the target held before this cycle's update.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            w_cur_next[i] = r_cur[i];
            if (w_wrap) begin
                if (r_tgt[i] > r_cur[i]) begin
                    if (int'(r_tgt[i] - r_cur[i]) > SLEW) begin
                        w_cur_next[i] = r_cur[i] + WIDTH'(SLEW);
                    end else begin
                        w_cur_next[i] = r_tgt[i];
                    end
                end else if (r_tgt[i] < r_cur[i]) begin
                    if (int'(r_cur[i] - r_tgt[i]) > SLEW) begin
                        w_cur_next[i] = r_cur[i] - WIDTH'(SLEW);
                    end else begin
                        w_cur_next[i] = r_tgt[i];
                    end
                end
            end
        end
    end

    always_comb begin
        w_pos_next = r_pos;
        for (int i = 0; i < CHANNELS; i++) begin
            if (int'(sel) == i) begin
                w_pos_next = r_cur[i];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_tick_cnt    <= '0;
            r_frame_cnt   <= '0;
            r_frame_start <= 1'b0;
            r_pwm         <= '0;
            r_settled     <= '1;
            r_pos         <= c_center;
            for (int i = 0; i < CHANNELS; i++) begin
                r_tgt[i] <= c_center;
                r_cur[i] <= c_center;
            end
        end else begin
            r_tick_cnt    <= w_tick ? '0 : r_tick_cnt + 1'b1;
            if (w_tick) begin
                r_frame_cnt <= w_wrap ? '0 : r_frame_cnt + 1'b1;
            end
            r_frame_start <= w_wrap;
            r_pos         <= w_pos_next;
            for (int i = 0; i < CHANNELS; i++) begin
                r_tgt[i]     <= w_tgt_next[i];
                r_cur[i]     <= w_cur_next[i];
                r_pwm[i]     <= (r_frame_cnt < r_cur[i]);
                r_settled[i] <= (r_cur[i] == r_tgt[i]);
            end
        end
    end

    assign pwm         = r_pwm;
    assign frame_start = r_frame_start;
    assign settled     = r_settled;
    assign pos_out     = r_pos;

endmodule
`default_nettype wire

// File: tb/tb_servo_pwm_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_servo_pwm_bank
// Description : Frame-level scoreboard bench for servo_pwm_bank.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_servo_pwm_bank;

    localparam int W = 12;
    localparam int TDIV = 4;
    localparam int FRAME_CYC = 200;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [1:0]   sel = '0;
    logic         inc = 1'b0;
    logic         dec = 1'b0;
    logic         wr_en = 1'b0;
    logic [1:0]   wr_ch = '0;
    logic [W-1:0] wr_data = '0;
    logic [3:0]   pwm;
    logic         frame_start;
    logic [3:0]   settled;
    logic [W-1:0] pos_out;

    servo_pwm_bank #(
        .CHANNELS(4), .WIDTH(W), .TICK_DIV(TDIV), .PERIOD_TICKS(50),
        .MIN_TICKS(10), .MAX_TICKS(20), .STEP(2), .SLEW(3)
    ) dut (
        .CLK(CLK), .RST(RST), .sel(sel), .inc(inc), .dec(dec),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
        .pwm(pwm), .frame_start(frame_start), .settled(settled), .pos_out(pos_out)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int cur0;
        int cur1;
        int cur2;
        int cur3;
        int settled;
        int pos;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d @%0t", name, act, req, $time);
        end
    endtask

    task automatic push(input int c0, input int c1, input int c2, input int c3,
                        input int st, input int pos);
        exp_t e;
        e.cur0 = c0; e.cur1 = c1; e.cur2 = c2; e.cur3 = c3;
        e.settled = st; e.pos = pos;
        sb.push_back(e);
    endtask

    // Monitor: one observation per completed frame window
    logic win_open = 1'b0;
    int   win_len = 0;
    int   win_cnt [4];
    int   obs_settled = 0;
    int   obs_pos = 0;
    int   frame_idx = 0;

    task automatic close_window();
        exp_t e;
        int   ec [4];
        frame_idx++;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame actual=frame%0d required=none", frame_idx);
        end else begin
            e = sb.pop_front();
            ec = '{e.cur0, e.cur1, e.cur2, e.cur3};
            for (int ch = 0; ch < 4; ch++) begin
                check($sformatf("frame%0d_pwm_high_ch%0d", frame_idx, ch), win_cnt[ch], ec[ch] * TDIV);
            end
            check($sformatf("frame%0d_len", frame_idx), win_len, FRAME_CYC);
            check($sformatf("frame%0d_settled", frame_idx), obs_settled, e.settled);
            check($sformatf("frame%0d_pos_out", frame_idx), obs_pos, e.pos);
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge CLK);
            if (RST) begin
                win_open = 1'b0;
            end else begin
                if (frame_start) begin
                    if (win_open) close_window();
                    win_open = 1'b1;
                    win_len  = 0;
                    for (int ch = 0; ch < 4; ch++) win_cnt[ch] = 0;
                end
                if (win_open) begin
                    win_len++;
                    for (int ch = 0; ch < 4; ch++) begin
                        if (pwm[ch]) win_cnt[ch]++;
                    end
                    if (win_len == 2) begin
                        obs_settled = int'(settled);
                        obs_pos     = int'(pos_out);
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_fs();
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!frame_start && n < 400);
        if (!frame_start) begin
            checks++;
            failures++;
            $display("FAIL frame_start_timeout actual=none required=pulse within 400 cycles");
        end
    endtask

    initial begin : stim
        int n;
        idle(3);
        check("rst_pwm", int'(pwm), 0);
        check("rst_frame_start", int'(frame_start), 0);
        check("rst_settled", int'(settled), 15);
        check("rst_pos_out", int'(pos_out), 15);
        RST = 1'b0;

        wait_fs(); push(15, 15, 15, 15, 4'b1111, 15);
        wait_fs(); push(15, 15, 15, 15, 4'b1111, 15);
        idle(20); sel = 2'd1;

        // four back-to-back inc on ch1: 17, 19, 20, 20
        wait_fs(); push(15, 15, 15, 15, 4'b1111, 15);
        idle(20); inc = 1'b1; idle(4); inc = 1'b0;
        wait_fs(); push(15, 18, 15, 15, 4'b1101, 18);
        wait_fs(); push(15, 20, 15, 15, 4'b1111, 20);

        // write below MIN clamps to 10
        idle(20); sel = 2'd2; wr_en = 1'b1; wr_ch = 2'd2; wr_data = 12'd3; idle(1); wr_en = 1'b0;
        wait_fs(); push(15, 20, 12, 15, 4'b1011, 12);

        // inc and dec together: no change on ch0
        idle(20); sel = 2'd0; inc = 1'b1; dec = 1'b1; idle(1); inc = 1'b0; dec = 1'b0; sel = 2'd2;
        wait_fs(); push(15, 20, 10, 15, 4'b1111, 10);

        // clamp-high write, write-beats-inc on ch0, write ch3 alongside inc ch0
        idle(20); wr_en = 1'b1; wr_ch = 2'd2; wr_data = 12'd4000; idle(1);
        wr_ch = 2'd0; wr_data = 12'd12; sel = 2'd0; inc = 1'b1; idle(1);
        wr_ch = 2'd3; wr_data = 12'd18; idle(1);
        wr_en = 1'b0; inc = 1'b0; sel = 2'd2;
        wait_fs(); push(14, 20, 13, 18, 4'b1011, 13);

        // mid-frame write at frame_cnt=30 must not touch this frame
        idle(121); wr_en = 1'b1; wr_ch = 2'd1; wr_data = 12'd10; idle(1); wr_en = 1'b0;
        wait_fs(); push(14, 17, 16, 18, 4'b1001, 16);

        // reset at frame_cnt=5 with every pulse high
        wait_fs();
        idle(21);
        check("pwm_before_reset", int'(pwm), 15);
        RST = 1'b1;
        idle(1);
        check("midrst_pwm", int'(pwm), 0);
        check("midrst_frame_start", int'(frame_start), 0);
        check("midrst_settled", int'(settled), 15);
        check("midrst_pos_out", int'(pos_out), 15);
        idle(1);
        RST = 1'b0;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!frame_start && n < 400);
        check("restart_first_frame_start", n, FRAME_CYC);
        push(15, 15, 15, 15, 4'b1111, 15);
        wait_fs();
        idle(2);
        check("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
